branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
In-order queue of in-flight branch predictions, sitting directly downstream of the saturating-counter predictor. Fetch pushes each predicted branch (table index plus predicted direction). Execute resolves branches in program order with the actual outcome. The block emits a registered update (index, actual direction) that drives the predictor's training inputs, plus a one-cycle flush pulse on mispredict.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2
IDX_W, 6, predictor table index width
CNT_W, 16, width of the saturating mispredict statistics counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
pred_valid  input  1  fetch presents a predicted branch
pred_ready  output  1  queue can accept; combinational, equals !full
pred_idx  input  IDX_W  predictor index of the branch
pred_taken  input  1  predicted direction
res_valid  input  1  execute resolves the oldest branch this cycle
res_taken  input  1  actual direction of the oldest branch
upd_valid  output  1  registered one-cycle pulse: training update valid
upd_idx  output  IDX_W  index of the resolved branch
upd_taken  output  1  actual direction, for the predictor's taken input
upd_mispredict  output  1  predicted direction != actual direction
flush  output  1  registered one-cycle pulse, coincident with upd_valid when upd_mispredict is 1
count  output  $clog2(DEPTH+1)  current occupancy
empty  output  1  count == 0
full  output  1  count == DEPTH
underflow  output  1  sticky flag: res_valid seen while empty
mispredict_cnt  output  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (async, rst_n low): pointers = 0, count = 0, and empty = 1, full = 0. upd_valid, upd_idx, upd_taken, upd_mispredict, flush, underflow and mispredict_cnt are all 0. Entry storage need not be reset.
- Push: occurs when pred_valid && pred_ready. Writes {pred_idx, pred_taken} at the tail and advances tail modulo DEPTH.
- Pop: occurs when res_valid && !empty. Reads the head entry combinationally and advances head modulo DEPTH.
- Update latency: exactly 1 cycle. On the edge after a pop, upd_valid = 1, upd_idx = head idx, upd_taken = res_taken, and upd_mispredict = (head pred != res_taken). Otherwise upd_valid = 0; the other upd_* fields hold their last values.
- Mispredict on pop: the entire queue is discarded at that edge, so count = 0 and head = tail. flush = 1 for one cycle, aligned with upd_valid. mispredict_cnt increments, saturating at all-ones.
- Push and correct pop in the same cycle: both take effect and count is unchanged.
- Push and mispredicting pop in the same cycle: the push handshake completes, but the new entry is discarded because it is a wrong-path younger branch. The queue ends empty.
- Full: pred_ready = 0 even if a pop occurs the same cycle. There is no bypass.
- Empty with res_valid: the request is ignored. upd_valid stays 0 and underflow is set; it clears only on reset.
- No update pulse is generated for discarded entries.
- count, empty and full are derived from registered state only. There is no combinational path from res_* to pred_ready.

Decomposition:
- Shared package bpu_pkg holds:
  - the typedef for a queue entry {idx, pred_taken};
  - the typedef for the update bundle {valid, idx, taken, mispredict};
  - default constants for IDX_W and DEPTH.
- One natural sub-module, brq_storage: a DEPTH x (IDX_W+1) register array with write port and asynchronous read at head.
- Pointers, count, flush logic and statistics stay in the top level.

Test Plan:
- Reset mid-operation: push 3 entries, assert rst_n low asynchronously between edges -> count = 0, empty = 1, upd_valid = 0, and mispredict_cnt = 0 immediately.
- Correct resolve:
  - push {idx 5, taken 1};
  - resolve res_taken = 1;
  - next cycle: upd_valid = 1, upd_idx = 5, upd_taken = 1, upd_mispredict = 0, flush = 0, count = 0.
- Mispredict flush:
  - push idx 1, 2, 3, each with pred 0;
  - resolve res_taken = 1;
  - next cycle: upd_idx = 1, upd_mispredict = 1, flush = 1, count = 0, mispredict_cnt = 1;
  - a later resolve sets underflow = 1.
- Fill to full:
  - push 8 entries (idx 0..7), then hold pred_valid -> pred_ready = 0 and count = 8;
  - a simultaneous correct pop leaves count = 7 and the extra push is not accepted.
- Wrap-around: perform 20 push/correct-resolve pairs, 3 in flight at a time -> upd_idx sequence matches push order exactly and count returns to 0.
- Simultaneous push and mispredict: queue holds idx 9 (pred 1), push idx 10 while resolving res_taken = 0 -> upd_idx = 9, flush = 1, count = 0, and idx 10 never appears on upd_idx.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and defaults for the branch resolve queue that sits
// downstream of the saturating-counter predictor.
package bpu_pkg;

    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned IDX_W_DEF = 6;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic                 pred_taken;
    } brq_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_W_DEF-1:0] idx;
        logic                 taken;
        logic                 mispredict;
    } brq_upd_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/training handshake bundle of the branch resolve queue.
// The slave side is the queue; the master side is the surrounding pipeline.
interface branch_resolve_queue_if
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
);

    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;

    logic             res_valid;
    logic             res_taken;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_mispredict;
    logic             flush;

    modport slave (
        input  pred_valid, pred_idx, pred_taken, res_valid, res_taken,
        output pred_ready, upd_valid, upd_idx, upd_taken, upd_mispredict, flush
    );

    modport master (
        output pred_valid, pred_idx, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_valid, upd_idx, upd_taken, upd_mispredict, flush
    );

endinterface

// File: rtl/branch_resolve_queue_storage.sv
// Entry array for the branch resolve queue: one synchronous write port,
// asynchronous read at the head pointer. Contents are not reset.
module brq_storage
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = IDX_W_DEF + 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; emits a registered
// training update per resolved branch and a flush pulse on mispredict.
module branch_resolve_queue
    import bpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    branch_resolve_queue_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         underflow,
    output logic [CNT_W-1:0]             mispredict_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    // Same shape as the package types, but tracking this instance's IDX_W.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred_taken;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic             mispredict;
    } upd_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;
    upd_t             upd_q, upd_d;
    logic             flush_q, flush_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic   push;
    logic   pop;
    logic   mispredict;
    entry_t wr_entry;
    entry_t rd_entry;

    brq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W + 1)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    // Status comes only from registered occupancy, so pred_ready never
    // depends on the resolve inputs.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == OCC_W'(DEPTH));
        push       = bus.pred_valid && !full;
        pop        = bus.res_valid && !empty;
        mispredict = pop && (rd_entry.pred_taken != bus.res_taken);
        wr_entry.idx        = bus.pred_idx;
        wr_entry.pred_taken = bus.pred_taken;
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        upd_d       = upd_q;
        upd_d.valid = 1'b0;
        flush_d     = 1'b0;
        underflow_d = underflow_q;
        mcnt_d      = mcnt_q;

        if (pop) begin
            upd_d.valid      = 1'b1;
            upd_d.idx        = rd_entry.idx;
            upd_d.taken      = bus.res_taken;
            upd_d.mispredict = mispredict;
            flush_d          = mispredict;
        end

        if (bus.res_valid && empty) begin
            underflow_d = 1'b1;
        end

        // A mispredict discards every younger entry, including one being
        // pushed this very cycle, so the tail is deliberately not advanced.
        if (mispredict) begin
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
            if (mcnt_q != '1) begin
                mcnt_d = mcnt_q + 1'b1;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            upd_q       <= '0;
            flush_q     <= 1'b0;
            underflow_q <= 1'b0;
            mcnt_q      <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_q       <= upd_d;
            flush_q     <= flush_d;
            underflow_q <= underflow_d;
            mcnt_q      <= mcnt_d;
        end
    end

    assign bus.pred_ready     = !full;
    assign bus.upd_valid      = upd_q.valid;
    assign bus.upd_idx        = upd_q.idx;
    assign bus.upd_taken      = upd_q.taken;
    assign bus.upd_mispredict = upd_q.mispredict;
    assign bus.flush          = flush_q;
    assign count              = count_q;
    assign underflow          = underflow_q;
    assign mispredict_cnt     = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 6;
    localparam int CNT_W = 3;
    localparam int MCNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pt;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             underflow;
    logic [CNT_W-1:0] mcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_queue_if #(.IDX_W(IDX_W)) bus ();

    branch_resolve_queue #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .underflow      (underflow),
        .mispredict_cnt (mcnt)
    );

    task automatic drive(input logic pv, input logic [IDX_W-1:0] pidx, input logic pt,
                         input logic rv, input logic rt);
        bus.pred_valid = pv;
        bus.pred_idx   = pidx;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
    endtask

    task automatic do_reset;
        bus.pred_valid = 1'b0;
        bus.pred_idx   = '0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
        checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.pred_ready); end
        checks++; if ({bus.upd_valid, bus.upd_idx, bus.upd_taken, bus.upd_mispredict, bus.flush} !== '0) begin
            errors++; $display("FAIL reset_upd got %0h exp 0", {bus.upd_valid, bus.upd_idx, bus.upd_taken, bus.upd_mispredict, bus.flush}); end
        checks++; if (underflow !== 1'b0 || mcnt !== '0) begin errors++; $display("FAIL reset_stats got uf=%0b mc=%0d exp 0/0", underflow, mcnt); end
        // Build up non-reset state, then assert reset between edges.
        drive(1, 6'd4, 0, 0, 0);
        drive(0, 6'd0, 0, 1, 1);
        drive(1, 6'd1, 1, 0, 0);
        drive(1, 6'd2, 1, 0, 0);
        drive(1, 6'd3, 1, 0, 0);
        drive(1, 6'd7, 1, 1, 1);
        checks++; if (count !== 4'd3 || bus.upd_valid !== 1'b1 || mcnt !== 3'd1) begin
            errors++; $display("FAIL pre_reset got cnt=%0d uv=%0b mc=%0d exp 3/1/1", count, bus.upd_valid, mcnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL async_reset_occ got cnt=%0d e=%0b f=%0b exp 0/1/0", count, empty, full); end
        checks++; if (bus.upd_valid !== 1'b0 || mcnt !== '0 || bus.upd_idx !== '0) begin
            errors++; $display("FAIL async_reset_upd got uv=%0b mc=%0d ui=%0d exp 0/0/0", bus.upd_valid, mcnt, bus.upd_idx); end
        do_reset();
    endtask

    task automatic test_correct_resolve;
        do_reset();
        drive(1, 6'd5, 1, 0, 0);
        checks++; if (count !== 4'd1 || bus.upd_valid !== 1'b0) begin errors++; $display("FAIL cr_push got cnt=%0d uv=%0b exp 1/0", count, bus.upd_valid); end
        drive(0, 6'd0, 0, 1, 1);
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_idx !== 6'd5 || bus.upd_taken !== 1'b1) begin
            errors++; $display("FAIL cr_upd got v=%0b i=%0d t=%0b exp 1/5/1", bus.upd_valid, bus.upd_idx, bus.upd_taken); end
        checks++; if (bus.upd_mispredict !== 1'b0 || bus.flush !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL cr_flags got m=%0b f=%0b cnt=%0d exp 0/0/0", bus.upd_mispredict, bus.flush, count); end
        drive(0, 6'd0, 0, 0, 0);
        checks++; if (bus.upd_valid !== 1'b0 || bus.upd_idx !== 6'd5) begin
            errors++; $display("FAIL cr_hold got v=%0b i=%0d exp 0/5", bus.upd_valid, bus.upd_idx); end
    endtask

    task automatic test_mispredict_flush;
        do_reset();
        for (int i = 1; i <= 3; i++) drive(1, 6'(i), 0, 0, 0);
        drive(0, 6'd0, 0, 1, 1);
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_idx !== 6'd1 || bus.upd_taken !== 1'b1 || bus.upd_mispredict !== 1'b1) begin
            errors++; $display("FAIL mf_upd got v=%0b i=%0d t=%0b m=%0b exp 1/1/1/1", bus.upd_valid, bus.upd_idx, bus.upd_taken, bus.upd_mispredict); end
        checks++; if (bus.flush !== 1'b1 || count !== 4'd0 || empty !== 1'b1 || mcnt !== 3'd1) begin
            errors++; $display("FAIL mf_flush got f=%0b cnt=%0d e=%0b mc=%0d exp 1/0/1/1", bus.flush, count, empty, mcnt); end
        drive(0, 6'd0, 0, 0, 0);
        checks++; if (bus.flush !== 1'b0 || bus.upd_valid !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL mf_after got f=%0b v=%0b uf=%0b exp 0/0/0", bus.flush, bus.upd_valid, underflow); end
        drive(0, 6'd0, 0, 1, 0);
        checks++; if (underflow !== 1'b1 || bus.upd_valid !== 1'b0 || mcnt !== 3'd1) begin
            errors++; $display("FAIL mf_underflow got uf=%0b v=%0b mc=%0d exp 1/0/1", underflow, bus.upd_valid, mcnt); end
        drive(1, 6'd8, 1, 0, 0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mf_sticky got %0b exp 1", underflow); end
    endtask

    task automatic test_fill_full;
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, 6'(i), 1, 0, 0);
        checks++; if (count !== 4'd8 || full !== 1'b1 || bus.pred_ready !== 1'b0) begin
            errors++; $display("FAIL ff_full got cnt=%0d f=%0b r=%0b exp 8/1/0", count, full, bus.pred_ready); end
        drive(1, 6'd42, 1, 1, 1);
        checks++; if (count !== 4'd7 || bus.upd_valid !== 1'b1 || bus.upd_idx !== 6'd0 || bus.pred_ready !== 1'b1) begin
            errors++; $display("FAIL ff_pop got cnt=%0d v=%0b i=%0d r=%0b exp 7/1/0/1", count, bus.upd_valid, bus.upd_idx, bus.pred_ready); end
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 6'd0, 0, 1, 1);
            checks++; if (bus.upd_valid !== 1'b1 || bus.upd_idx !== 6'(i)) begin
                errors++; $display("FAIL ff_drain got v=%0b i=%0d exp 1/%0d", bus.upd_valid, bus.upd_idx, i); end
        end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL ff_end got cnt=%0d e=%0b exp 0/1", count, empty); end
    endtask

    task automatic test_wrap_around;
        logic pts [20];
        do_reset();
        for (int i = 0; i < 20; i++) pts[i] = 1'($urandom);
        for (int i = 0; i < 3; i++) drive(1, 6'(20 + i), pts[i], 0, 0);
        for (int i = 3; i < 20; i++) begin
            drive(1, 6'(20 + i), pts[i], 1, pts[i-3]);
            checks++; if (bus.upd_idx !== 6'(20 + i - 3) || bus.upd_mispredict !== 1'b0 || count !== 4'd3) begin
                errors++; $display("FAIL wrap_seq got i=%0d m=%0b cnt=%0d exp %0d/0/3", bus.upd_idx, bus.upd_mispredict, count, 20 + i - 3); end
        end
        for (int i = 17; i < 20; i++) begin
            drive(0, 6'd0, 0, 1, pts[i]);
            checks++; if (bus.upd_idx !== 6'(20 + i) || bus.upd_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_drain got i=%0d v=%0b exp %0d/1", bus.upd_idx, bus.upd_valid, 20 + i); end
        end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_end got cnt=%0d e=%0b exp 0/1", count, empty); end
    endtask

    task automatic test_push_mispredict;
        do_reset();
        drive(1, 6'd9, 1, 0, 0);
        drive(1, 6'd10, 0, 1, 0);
        checks++; if (bus.upd_idx !== 6'd9 || bus.upd_mispredict !== 1'b1 || bus.flush !== 1'b1) begin
            errors++; $display("FAIL pm_upd got i=%0d m=%0b f=%0b exp 9/1/1", bus.upd_idx, bus.upd_mispredict, bus.flush); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL pm_count got cnt=%0d e=%0b exp 0/1", count, empty); end
        drive(0, 6'd0, 0, 1, 1);
        checks++; if (bus.upd_valid !== 1'b0 || bus.upd_idx !== 6'd9 || underflow !== 1'b1) begin
            errors++; $display("FAIL pm_discard got v=%0b i=%0d uf=%0b exp 0/9/1", bus.upd_valid, bus.upd_idx, underflow); end
        drive(1, 6'd11, 0, 0, 0);
        drive(0, 6'd0, 0, 1, 0);
        checks++; if (bus.upd_idx !== 6'd11 || bus.upd_mispredict !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL pm_next got i=%0d m=%0b cnt=%0d exp 11/0/0", bus.upd_idx, bus.upd_mispredict, count); end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1, 6'(k), 0, 0, 0);
            drive(0, 6'd0, 0, 1, 1);
            checks++; if (mcnt !== CNT_W'((k < MCNT_MAX) ? k : MCNT_MAX)) begin
                errors++; $display("FAIL sat_cnt got %0d exp %0d", mcnt, (k < MCNT_MAX) ? k : MCNT_MAX); end
        end
    endtask

    task automatic test_random;
        ent_t             mq[$];
        ent_t             h;
        logic             pv, pt, rv, rt, rdy, psh, pp, mis;
        logic [IDX_W-1:0] pidx;
        logic             m_uv = 0, m_ut = 0, m_um = 0, m_fl = 0, m_uf = 0;
        logic [IDX_W-1:0] m_ui = '0;
        int               m_mc = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pv   = ($urandom_range(0, 9) < 6);
            pidx = IDX_W'($urandom);
            pt   = 1'($urandom);
            rv   = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0) rt = ($urandom_range(0, 9) < 8) ? mq[0].pt : ~mq[0].pt;
            else rt = 1'($urandom);
            rdy = (mq.size() < DEPTH);
            checks++; if (bus.pred_ready !== rdy) begin errors++; $display("FAIL rnd_ready got %0b exp %0b", bus.pred_ready, rdy); end
            psh = pv && rdy;
            pp  = rv && (mq.size() > 0);
            mis = 1'b0;
            m_uv = 1'b0;
            m_fl = 1'b0;
            if (pp) begin
                h = mq.pop_front();
                m_uv = 1'b1; m_ui = h.idx; m_ut = rt;
                mis = (h.pt != rt);
                m_um = mis;
                if (mis) begin
                    mq.delete();
                    m_fl = 1'b1;
                    if (m_mc < MCNT_MAX) m_mc++;
                end
            end
            if (rv && !pp) m_uf = 1'b1;
            if (psh && !mis) mq.push_back('{idx: pidx, pt: pt});
            drive(pv, pidx, pt, rv, rt);
            checks++; if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_occ got cnt=%0d e=%0b f=%0b exp %0d", count, empty, full, mq.size()); end
            checks++; if (bus.upd_valid !== m_uv || bus.flush !== m_fl) begin
                errors++; $display("FAIL rnd_pulse got v=%0b f=%0b exp %0b/%0b", bus.upd_valid, bus.flush, m_uv, m_fl); end
            checks++; if (bus.upd_idx !== m_ui || bus.upd_taken !== m_ut || bus.upd_mispredict !== m_um) begin
                errors++; $display("FAIL rnd_upd got i=%0d t=%0b m=%0b exp %0d/%0b/%0b", bus.upd_idx, bus.upd_taken, bus.upd_mispredict, m_ui, m_ut, m_um); end
            checks++; if (underflow !== m_uf || mcnt !== CNT_W'(m_mc)) begin
                errors++; $display("FAIL rnd_stats got uf=%0b mc=%0d exp %0b/%0d", underflow, mcnt, m_uf, m_mc); end
        end
    endtask

    initial begin
        test_reset();
        test_correct_resolve();
        test_mispredict_flush();
        test_fill_full();
        test_wrap_around();
        test_push_mispredict();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
